escalonar_ativo: RTL



---
 rtl/escalonar_ativo_pkg.sv | 19 +
 rtl/escalonar_ativo.sv | 120 ++++++++++++
 2 files changed

// File: rtl/escalonar_ativo_pkg.sv
// Shared definitions for the active-node scheduler and its classifier:
// default geometry and the controller state encoding.
package escalonar_ativo_pkg;

  localparam int NUM_NA_DEF         = 8;
  localparam int CRITERIO_WIDTH_DEF = 5;
  localparam int INDEX_WIDTH_DEF    = 3;
  localparam int TIMEOUT_DEF        = NUM_NA_DEF + 4;
  localparam int TIMER_WIDTH_DEF    = 4;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    DISPARA = 3'd1,
    ESPERA  = 3'd2,
    BUSCA   = 3'd3,
    ENTREGA = 3'd4
  } ea_state_e;

endpackage

// File: rtl/escalonar_ativo.sv
// Scheduler: fires the classifier, waits for its minimum (with timeout), then
// scans the active nodes for the first one holding that minimum and hands it out.
module escalonar_ativo
  import escalonar_ativo_pkg::*;
#(
  parameter int NUM_NA         = NUM_NA_DEF,
  parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_DEF,
  parameter int INDEX_WIDTH    = INDEX_WIDTH_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int TIMER_WIDTH    = TIMER_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ea_iniciar_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  output logic                             ea_atualizar_out,
  output logic                             ea_ocupado_o,
  output logic                             ea_valido_o,
  output logic [INDEX_WIDTH-1:0]           ea_indice_out,
  output logic [CRITERIO_WIDTH-1:0]        ea_criterio_out,
  input  logic                             ea_ack_in,
  output logic                             ea_vazio_o,
  output logic                             ea_erro_o
);

  localparam logic [INDEX_WIDTH-1:0] LastIdx     = INDEX_WIDTH'(NUM_NA - 1);
  localparam logic [TIMER_WIDTH-1:0] TimeoutLast = TIMER_WIDTH'(TIMEOUT - 1);

  ea_state_e                 state_q;
  logic [TIMER_WIDTH-1:0]    timer_q;
  logic [TIMER_WIDTH-1:0]    timer_d;
  logic [INDEX_WIDTH-1:0]    scanIdx_q;
  logic [CRITERIO_WIDTH-1:0] minimo_q;
  logic [INDEX_WIDTH-1:0]    indice_q;
  logic [CRITERIO_WIDTH-1:0] criterio_q;
  logic                      valido_q;
  logic                      vazio_q;
  logic                      erro_q;

  logic [CRITERIO_WIDTH-1:0] criterioNo [NUM_NA];
  logic                      nodeMatch;

  for (genvar g = 0; g < NUM_NA; g++) begin : g_unpack
    assign criterioNo[g] = na_criterio_in[CRITERIO_WIDTH*g +: CRITERIO_WIDTH];
  end

  assign timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign nodeMatch = na_ativo_in[scanIdx_q] && (criterioNo[scanIdx_q] == minimo_q);

  // timer_q==0 marks the first ESPERA cycle, where pronto is still left over
  // from the previous classifier run and must not be trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCIOSO;
      timer_q    <= '0;
      scanIdx_q  <= '0;
      minimo_q   <= '0;
      indice_q   <= '0;
      criterio_q <= '0;
      valido_q   <= 1'b0;
      vazio_q    <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      vazio_q <= 1'b0;
      erro_q  <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (ea_iniciar_in) state_q <= DISPARA;
        end
        DISPARA: begin
          timer_q <= '0;
          state_q <= ESPERA;
        end
        ESPERA: begin
          timer_q <= timer_d;
          if ((timer_q != '0) && ca_pronto_in) begin
            minimo_q  <= ca_criterio_geral_in;
            scanIdx_q <= '0;
            state_q   <= BUSCA;
          end else if (timer_q == TimeoutLast) begin
            erro_q  <= 1'b1;
            state_q <= OCIOSO;
          end
        end
        BUSCA: begin
          if (nodeMatch) begin
            indice_q   <= scanIdx_q;
            criterio_q <= criterioNo[scanIdx_q];
            valido_q   <= 1'b1;
            state_q    <= ENTREGA;
          end else if (scanIdx_q == LastIdx) begin
            vazio_q <= 1'b1;
            state_q <= OCIOSO;
          end else begin
            scanIdx_q <= scanIdx_q + 1'b1;
          end
        end
        ENTREGA: begin
          if (ea_ack_in) begin
            valido_q <= 1'b0;
            state_q  <= ea_iniciar_in ? DISPARA : OCIOSO;
          end
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign ea_atualizar_out = (state_q == DISPARA);
  assign ea_ocupado_o     = (state_q != OCIOSO);
  assign ea_valido_o      = valido_q;
  assign ea_indice_out    = indice_q;
  assign ea_criterio_out  = criterio_q;
  assign ea_vazio_o       = vazio_q;
  assign ea_erro_o        = erro_q;

endmodule
